tick_divider: RTL and testbench
===============================

Name: tick_divider

Overview:
Parametrised successor to the fixed divide-by-100 clock divider. Divides clk by a runtime-loadable divisor N and produces:
- a one-cycle tick strobe per period
- a near-50% duty clk_out square wave (used as a clock enable, not as a real clock)
- the live phase count

It feeds the microwave timer and display-scan logic, for example 1 Hz and 1 kHz enables from the system clock.

Parameters:
WIDTH, 16, width of the divisor and the counter.
DEFAULT_DIV, 100, divisor active after reset; must fit in WIDTH bits; a value of 0 is treated as 1.

Ports:
clk  input  1  system clock; all logic on the rising edge.
rst  input  1  synchronous, active-high reset.
en  input  1  count enable; when low, all state holds.
div_load  input  1  single-cycle request to load div_val as the new divisor.
div_val  input  WIDTH  requested divisor; 0 is treated as 1.
tick  output  1  one-cycle pulse, once per N enabled cycles.
clk_out  output  1  divided square wave, period N enabled cycles.
count  output  WIDTH  current phase, 0..N-1.
pending  output  1  a loaded divisor is waiting for the next period boundary.

Behaviour:
- Reset (synchronous, active-high, may arrive at any time):
  - count=0, tick=0, clk_out=1, pending=0.
  - Active divisor = DEFAULT_DIV; shadow divisor cleared.
  - Reset overrides en and div_load in the same cycle.
- Effective divisor: N = max(active divisor, 1).
- Counting (en=1):
  - If count==N-1: count goes to 0 (wrap).
  - Otherwise: count+1.
- Holding (en=0): count, clk_out and pending hold; tick is 0.
- tick timing:
  - Registered; high for exactly one cycle, the cycle in which count==0 immediately after a wrap.
  - First tick comes N enabled cycles after reset release.
  - Never asserted on the reset cycle or while en=0.
- clk_out:
  - Registered; clk_out = (count < H), where H = (N+1)>>1, evaluated on the next count value.
  - N=100: 50 cycles high, 50 low. N=3: 2 high, 1 low. N=1: constantly 1, with tick every enabled cycle.
- Divisor loading:
  - div_load=1 captures div_val into the shadow register and sets pending=1.
  - A later load before the boundary overwrites the shadow (latest wins).
  - On a wrap, if pending: active divisor = shadow, pending clears, and the new N governs the period starting at count 0.
  - If div_load coincides with a wrap, the incoming div_val is applied directly at that wrap and pending stays 0.
  - A load while en=0 is captured; it applies at the first wrap after en returns.
- Divisor below current phase: if a new N would make count ≥ N-1, that cannot occur, because changes only apply at count 0.
- Arithmetic:
  - All compares are unsigned, WIDTH bits.
  - H is computed as WIDTH+1 bits so that N = 2^WIDTH-1 does not overflow.
  - No other wrap-around beyond N-1.

Optional Feature:
Macro TICK_DIVIDER_SYNC_CLR_EN.
- Defined: adds input clr (1 bit).
  - clr=1 (with rst=0) forces count=0, tick=0, clk_out=1.
  - Any pending shadow divisor is applied immediately and pending clears.
  - clr works regardless of en.
  - rst has priority over clr.
- Undefined: the port is absent; the phase can only be restarted by rst.

Decomposition:
Shared package div_pkg holds:
- DIV_WIDTH_DEF=16 and DIV_DEFAULT=100 constants
- function eff_div (0 maps to 1)
- function half_up ((N+1)>>1)

One natural sub-module is div_shadow: active/shadow divisor registers plus the pending flag and the apply-at-boundary logic. The counter, tick and clk_out logic stays in tick_divider.

Test Plan:
- Default divisor: rst 2 cycles, en=1 for 250 cycles -> ticks at cycles 100 and 200 after release; clk_out high for count 0..49 and low for 50..99.
- Enable gating: en toggled 1/0 every cycle, N=4 -> tick every 8 clk cycles; count and clk_out hold on en=0 cycles; tick never high while en=0.
- Deferred load: at count=10 with N=100, load div_val=5 -> pending=1 until the wrap, then ticks every 5 cycles; clk_out 3 high / 2 low.
- Load at boundary and edge values: load div_val=0 exactly at the wrap -> N=1, pending stays 0, tick every cycle, clk_out constantly 1. Then load 1 followed by 7 before the next boundary -> 7 wins.
- Reset mid-period: rst at count=37 with pending=1 -> next cycle count=0, tick=0, clk_out=1, pending=0, N=100 restored.
- With TICK_DIVIDER_SYNC_CLR_EN: clr at count=60, pending div=20 -> count=0 and clk_out=1 next cycle; next tick 20 cycles later. rst and clr together -> reset values, DEFAULT_DIV active.

Source files
------------

// File: rtl/div_pkg.sv
// Shared constants and divisor helpers for the tick divider.
// Helpers work on 32-bit values, so WIDTH is limited to 32.
package div_pkg;

    localparam int DIV_WIDTH_DEF = 16;
    localparam int DIV_DEFAULT   = 100;

    function automatic logic [31:0] eff_div(input logic [31:0] d);
        return (d == 32'd0) ? 32'd1 : d;
    endfunction

    function automatic logic [32:0] half_up(input logic [31:0] n);
        return ({1'b0, n} + 33'd1) >> 1;
    endfunction

endpackage

// File: rtl/div_shadow.sv
// Active/shadow divisor registers with the pending flag.
// A load becomes active only when the counter signals a period boundary.
module div_shadow
    import div_pkg::*;
#(
    parameter int WIDTH       = DIV_WIDTH_DEF,
    parameter int DEFAULT_DIV = DIV_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             apply,
    input  logic             div_load,
    input  logic [WIDTH-1:0] div_val,
    output logic [WIDTH-1:0] div_n,
    output logic             pending
);

    logic [WIDTH-1:0] active_q;
    logic [WIDTH-1:0] shadow_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            active_q <= WIDTH'(DEFAULT_DIV);
            shadow_q <= '0;
            pending  <= 1'b0;
        end else if (apply) begin
            // a load arriving at the boundary bypasses the shadow
            if (div_load)
                active_q <= div_val;
            else if (pending)
                active_q <= shadow_q;
            pending <= 1'b0;
        end else if (div_load) begin
            shadow_q <= div_val;
            pending  <= 1'b1;
        end
    end

    assign div_n = WIDTH'(eff_div(32'(active_q)));

endmodule

// File: rtl/tick_divider.sv
// Runtime-loadable clock divider producing tick, clk_out and phase.
// Define TICK_DIVIDER_SYNC_CLR_EN to add the synchronous clr input.
module tick_divider
    import div_pkg::*;
#(
    parameter int WIDTH       = DIV_WIDTH_DEF,
    parameter int DEFAULT_DIV = DIV_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             div_load,
    input  logic [WIDTH-1:0] div_val,
`ifdef TICK_DIVIDER_SYNC_CLR_EN
    input  logic             clr,
`endif
    output logic             tick,
    output logic             clk_out,
    output logic [WIDTH-1:0] count,
    output logic             pending
);

    logic             clr_i;
    logic [WIDTH-1:0] div_n;
    logic [WIDTH-1:0] count_inc;
    logic [WIDTH:0]   half;
    logic             wrap;
    logic             apply;

`ifdef TICK_DIVIDER_SYNC_CLR_EN
    assign clr_i = clr;
`else
    assign clr_i = 1'b0;
`endif

    assign wrap      = (count == div_n - WIDTH'(1));
    assign count_inc = count + WIDTH'(1);
    assign apply     = clr_i | (en & wrap);
    assign half      = (WIDTH+1)'(half_up(32'(div_n)));

    div_shadow #(
        .WIDTH       (WIDTH),
        .DEFAULT_DIV (DEFAULT_DIV)
    ) u_shadow (
        .clk      (clk),
        .rst      (rst),
        .apply    (apply),
        .div_load (div_load),
        .div_val  (div_val),
        .div_n    (div_n),
        .pending  (pending)
    );

    // on a wrap the next phase is 0, which is always in the high half
    always_ff @(posedge clk) begin
        if (rst || clr_i) begin
            count   <= '0;
            tick    <= 1'b0;
            clk_out <= 1'b1;
        end else if (en) begin
            tick    <= wrap;
            count   <= wrap ? '0 : count_inc;
            clk_out <= wrap | ({1'b0, count_inc} < half);
        end else begin
            tick <= 1'b0;
        end
    end

endmodule

// File: tb/tb_tick_divider.sv
// Randomised and directed bench for tick_divider against a phase model.
// Clr scenarios are built only with TICK_DIVIDER_SYNC_CLR_EN.
module tb_tick_divider;

    localparam int W   = 16;
    localparam int DEF = 100;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         en = 1'b0;
    logic         div_load = 1'b0;
    logic [W-1:0] div_val = '0;
`ifdef TICK_DIVIDER_SYNC_CLR_EN
    logic         clr = 1'b0;
`endif
    logic         tick;
    logic         clk_out;
    logic [W-1:0] count;
    logic         pending;

    int n_vec = 0;
    int n_err = 0;

    // reference model: phase and divisor as plain integers
    int m_ph = 0;
    int m_act = DEF;
    int m_sh = 0;
    bit m_pend = 0;
    bit m_tk = 0;
    bit m_co = 1;

    always #5 clk = ~clk;

    tick_divider #(
        .WIDTH       (W),
        .DEFAULT_DIV (DEF)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .div_load (div_load),
        .div_val  (div_val),
`ifdef TICK_DIVIDER_SYNC_CLR_EN
        .clr      (clr),
`endif
        .tick     (tick),
        .clk_out  (clk_out),
        .count    (count),
        .pending  (pending)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     tag, got, exp, $time);
        end
    endtask

    function automatic int eff(input int d);
        return (d == 0) ? 1 : d;
    endfunction

    task automatic model(input bit r, input bit e, input bit ld,
                         input int v, input bit c);
        if (r) begin
            m_ph = 0; m_tk = 0; m_co = 1;
            m_pend = 0; m_act = DEF; m_sh = 0;
        end else if (c) begin
            if (ld) m_act = v;
            else if (m_pend) m_act = m_sh;
            m_pend = 0; m_ph = 0; m_tk = 0; m_co = 1;
        end else if (e) begin
            m_ph = (m_ph + 1) % eff(m_act);
            m_tk = (m_ph == 0);
            if (m_tk) begin
                if (ld) m_act = v;
                else if (m_pend) m_act = m_sh;
                m_pend = 0;
            end else if (ld) begin
                m_sh = v; m_pend = 1;
            end
            m_co = m_ph < (eff(m_act) + 1) / 2;
        end else begin
            m_tk = 0;
            if (ld) begin
                m_sh = v; m_pend = 1;
            end
        end
    endtask

    task automatic step(input bit r, input bit e, input bit ld,
                        input int v, input bit c);
        rst      = r;
        en       = e;
        div_load = ld;
        div_val  = W'(v);
`ifdef TICK_DIVIDER_SYNC_CLR_EN
        clr      = c;
`endif
        @(posedge clk);
        model(r, e, ld, v, c);
        #1;
        check("tick", 32'(tick), 32'(m_tk));
        check("clk_out", 32'(clk_out), 32'(m_co));
        check("count", 32'(count), 32'(m_ph));
        check("pending", 32'(pending), 32'(m_pend));
    endtask

    task automatic run(input int cycles);
        for (int i = 0; i < cycles; i++) step(0, 1, 0, 0, 0);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int ticks;
        int first;
        int highs;
        int r;
        int v;

        // default divisor: ticks at 100 and 200, 50 high per period
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_clk_out", 32'(clk_out), 32'd1);
        ticks = 0; first = -1; highs = 0;
        for (int i = 1; i <= 250; i++) begin
            step(0, 1, 0, 0, 0);
            if (i <= 100 && clk_out) highs++;
            if (tick) begin
                ticks++;
                if (first < 0) first = i;
            end
        end
        check("dflt_ticks", 32'(ticks), 32'd2);
        check("dflt_first", 32'(first), 32'd100);
        check("dflt_high", 32'(highs), 32'd50);

        // load 4 right at the wrap, then toggle en
        step(1, 0, 0, 0, 0);
        run(99);
        step(0, 1, 1, 4, 0);
        check("bnd_pending", 32'(pending), 32'd0);
        ticks = 0;
        for (int i = 0; i < 40; i++) begin
            step(0, (i % 2) == 0, 0, 0, 0);
            if (tick) ticks++;
        end
        check("gate_ticks", 32'(ticks), 32'd5);

        // deferred load of 5 at phase 10
        step(1, 0, 0, 0, 0);
        run(10);
        step(0, 1, 1, 5, 0);
        check("defer_pending", 32'(pending), 32'd1);
        run(89);
        ticks = 0; highs = 0;
        for (int i = 0; i < 20; i++) begin
            step(0, 1, 0, 0, 0);
            if (tick) ticks++;
            if (clk_out) highs++;
        end
        check("defer_ticks", 32'(ticks), 32'd4);
        check("defer_high", 32'(highs), 32'd12);

        // load 0 exactly at the wrap, then 1 and 7 while disabled
        for (int i = 0; i < 200 && m_ph != eff(m_act) - 1; i++)
            step(0, 1, 0, 0, 0);
        step(0, 1, 1, 0, 0);
        check("zero_pending", 32'(pending), 32'd0);
        ticks = 0;
        for (int i = 0; i < 6; i++) begin
            step(0, 1, 0, 0, 0);
            if (tick && clk_out) ticks++;
        end
        check("n1_ticks", 32'(ticks), 32'd6);
        step(0, 0, 1, 1, 0);
        step(0, 0, 1, 7, 0);
        run(1);
        ticks = 0;
        for (int i = 0; i < 21; i++) begin
            step(0, 1, 0, 0, 0);
            if (tick) ticks++;
        end
        check("latest_ticks", 32'(ticks), 32'd3);

        // reset mid-period with a pending divisor
        step(1, 0, 0, 0, 0);
        run(30);
        step(0, 1, 1, 9, 0);
        run(6);
        check("pre_rst_count", 32'(count), 32'd37);
        step(1, 1, 1, 3, 0);
        check("rst_mid_pend", 32'(pending), 32'd0);
        run(110);

`ifdef TICK_DIVIDER_SYNC_CLR_EN
        step(1, 0, 0, 0, 0);
        run(50);
        step(0, 1, 1, 20, 0);
        run(9);
        check("pre_clr_count", 32'(count), 32'd60);
        step(0, 0, 0, 0, 1);
        check("clr_count", 32'(count), 32'd0);
        first = -1;
        for (int i = 1; i <= 25; i++) begin
            step(0, 1, 0, 0, 0);
            if (tick && first < 0) first = i;
        end
        check("clr_first", 32'(first), 32'd20);
        step(0, 1, 1, 6, 0);
        step(1, 1, 0, 0, 1);
        run(120);
`endif

        // random traffic
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 3000; i++) begin
            r = $urandom_range(0, 999);
            v = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 300)
                                             : $urandom_range(0, 9);
            step(r < 4, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 19) == 0, v,
`ifdef TICK_DIVIDER_SYNC_CLR_EN
                 $urandom_range(0, 99) == 0
`else
                 1'b0
`endif
                 );
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
